// File: rtl/vga_timing_out_if.sv
// Signal bundle between the VGA timing/output stage and the draw stage plus connector pins.
// The master side is the timing block. The slave side is the draw stage and the pins.
interface vga_timing_out_if;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       frame_start;
  logic [7:0] rgb_in;
  logic       hsync;
  logic       vsync;
  logic [2:0] vga_red;
  logic [2:0] vga_green;
  logic [1:0] vga_blue;

  modport master (
    output h_count, v_count, frame_start, hsync, vsync, vga_red, vga_green, vga_blue,
    input  rgb_in
  );

  modport slave (
    input  h_count, v_count, frame_start, hsync, vsync, vga_red, vga_green, vga_blue,
    output rgb_in
  );
endinterface

// File: rtl/vga_timing_out.sv
// 640x480@60 VGA timing generator. Sync and active flags are delayed to line up with the
// registered pixel from the draw stage, then the colour is blanked and the pins are registered.
module vga_timing_out #(
  parameter int unsigned H_TOTAL        = 800,
  parameter int unsigned H_SYNC         = 96,
  parameter int unsigned H_ACTIVE_START = 144,
  parameter int unsigned H_ACTIVE_END   = 784,
  parameter int unsigned V_TOTAL        = 525,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_ACTIVE_START = 35,
  parameter int unsigned V_ACTIVE_END   = 515,
  parameter int unsigned PIPE_DELAY     = 1
) (
  input  logic              clk_25,
  input  logic              rst_n,
  vga_timing_out_if.master  vga
);

  localparam logic [9:0] HLast = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast = 10'(V_TOTAL - 1);
  localparam logic [9:0] HSync = 10'(H_SYNC);
  localparam logic [9:0] VSync = 10'(V_SYNC);
  localparam logic [9:0] HActS = 10'(H_ACTIVE_START);
  localparam logic [9:0] HActE = 10'(H_ACTIVE_END);
  localparam logic [9:0] VActS = 10'(V_ACTIVE_START);
  localparam logic [9:0] VActE = 10'(V_ACTIVE_END);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       frame_start_q;
  logic       hs_raw, vs_raw, act_raw;

  // Each stage holds {hs, vs, act}; stage PIPE_DELAY-1 is the tap aligned with rgb_in.
  logic [PIPE_DELAY-1:0][2:0] pipe_q, pipe_d;
  logic [2:0]                 tap;

  logic       hsync_q, vsync_q;
  logic [7:0] rgb_q;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == HLast) begin
      h_d = 10'd0;
      v_d = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
    end
  end

  always_comb begin
    hs_raw  = (h_q >= HSync);
    vs_raw  = (v_q >= VSync);
    act_raw = (h_q >= HActS) && (h_q < HActE) && (v_q >= VActS) && (v_q < VActE);
  end

  always_comb begin
    pipe_d    = pipe_q << 3;
    pipe_d[0] = {hs_raw, vs_raw, act_raw};
  end

  assign tap = pipe_q[PIPE_DELAY-1];

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      frame_start_q <= 1'b0;
      pipe_q        <= {PIPE_DELAY{3'b110}};
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= 8'h00;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= (h_d == 10'd0) && (v_d == 10'd0);
      pipe_q        <= pipe_d;
      hsync_q       <= tap[2];
      vsync_q       <= tap[1];
      // Gate on the delayed active flag so blanking-time garbage never reaches the DAC.
      rgb_q         <= tap[0] ? vga.rgb_in : 8'h00;
    end
  end

  assign vga.h_count     = h_q;
  assign vga.v_count     = v_q;
  assign vga.frame_start = frame_start_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.vga_red     = rgb_q[7:5];
  assign vga.vga_green   = rgb_q[4:2];
  assign vga.vga_blue    = rgb_q[1:0];

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: full-timing instances with PIPE_DELAY 1 and 3, plus a scaled-down
// timing instance (20x8, PIPE_DELAY 2) so frame wrap and frame_start are reachable quickly.
module tb_vga_timing_out;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   fs1_cnt = 0;
  int   fss_cnt = 0;

  always #20 clk = ~clk;

  vga_timing_out_if if1 ();
  vga_timing_out_if if3 ();
  vga_timing_out_if ifs ();

  vga_timing_out #(.PIPE_DELAY(1)) u_dut1 (.clk_25(clk), .rst_n(rst_n), .vga(if1));
  vga_timing_out #(.PIPE_DELAY(3)) u_dut3 (.clk_25(clk), .rst_n(rst_n), .vga(if3));
  vga_timing_out #(
    .H_TOTAL(20), .H_SYNC(3), .H_ACTIVE_START(5), .H_ACTIVE_END(17),
    .V_TOTAL(8), .V_SYNC(2), .V_ACTIVE_START(3), .V_ACTIVE_END(7), .PIPE_DELAY(2)
  ) u_duts (.clk_25(clk), .rst_n(rst_n), .vga(ifs));

  // Draw-stage stand-ins: pixel = h_count[7:0] registered PIPE_DELAY times.
  logic [7:0] d1_q;
  logic [7:0] d3_q [3];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q    <= 8'h00;
      d3_q[0] <= 8'h00;
      d3_q[1] <= 8'h00;
      d3_q[2] <= 8'h00;
    end else begin
      d1_q    <= if1.h_count[7:0];
      d3_q[0] <= if3.h_count[7:0];
      d3_q[1] <= d3_q[0];
      d3_q[2] <= d3_q[1];
    end
  end
  assign if1.rgb_in = d1_q;
  assign if3.rgb_in = d3_q[2];
  assign ifs.rgb_in = 8'hE3;

  always @(negedge clk) begin
    if (rst_n && if1.frame_start) fs1_cnt++;
    if (rst_n && ifs.frame_start) fss_cnt++;
  end

  typedef struct {
    int         n;
    int         sel;
    logic [9:0] h;
    logic [9:0] v;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
  } vec_t;

  vec_t tv[$];

  function automatic void add(int n, int sel, int h, int v, bit fs, bit hs, bit vs,
                              logic [7:0] rgb);
    vec_t e;
    e.n = n; e.sel = sel; e.h = 10'(h); e.v = 10'(v);
    e.fs = fs; e.hs = hs; e.vs = vs; e.rgb = rgb;
    tv.push_back(e);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] pins(int sel);
    case (sel)
      0:       return {if1.vga_red, if1.vga_green, if1.vga_blue};
      1:       return {if3.vga_red, if3.vga_green, if3.vga_blue};
      default: return {ifs.vga_red, ifs.vga_green, ifs.vga_blue};
    endcase
  endfunction

  initial begin
    // sel 0: PIPE_DELAY=1 full timing, sel 1: PIPE_DELAY=3 full timing, sel 2: scaled timing.
    add(0,     0,   0,  0, 0, 1, 1, 8'h00);
    add(0,     2,   0,  0, 0, 1, 1, 8'h00);
    add(1,     0,   1,  0, 0, 1, 1, 8'h00);
    add(2,     0,   2,  0, 0, 0, 0, 8'h00);
    add(2,     2,   2,  0, 0, 1, 1, 8'h00);
    add(3,     1,   3,  0, 0, 1, 1, 8'h00);
    add(3,     2,   3,  0, 0, 0, 0, 8'h00);
    add(4,     1,   4,  0, 0, 0, 0, 8'h00);
    add(39,    2,  19,  1, 0, 1, 0, 8'h00);
    add(59,    2,  19,  2, 0, 1, 1, 8'h00);
    add(60,    2,   0,  3, 0, 1, 1, 8'h00);
    add(67,    2,   7,  3, 0, 1, 1, 8'h00);
    add(68,    2,   8,  3, 0, 1, 1, 8'hE3);
    add(97,    0,  97,  0, 0, 0, 0, 8'h00);
    add(98,    0,  98,  0, 0, 1, 0, 8'h00);
    add(139,   2,  19,  6, 0, 1, 1, 8'hE3);
    add(140,   2,   0,  7, 0, 1, 1, 8'h00);
    add(159,   2,  19,  7, 0, 1, 1, 8'h00);
    add(160,   2,   0,  0, 1, 1, 1, 8'h00);
    add(161,   2,   1,  0, 0, 1, 1, 8'h00);
    add(163,   2,   3,  0, 0, 0, 0, 8'h00);
    add(320,   2,   0,  0, 1, 1, 1, 8'h00);
    add(799,   0, 799,  0, 0, 1, 0, 8'h00);
    add(800,   0,   0,  1, 0, 1, 0, 8'h00);
    add(802,   0,   2,  1, 0, 0, 0, 8'h00);
    add(1601,  0,   1,  2, 0, 1, 0, 8'h00);
    add(1602,  0,   2,  2, 0, 0, 1, 8'h00);
    add(8799,  0, 799, 10, 0, 1, 1, 8'h00);
    add(8800,  0,   0, 11, 0, 1, 1, 8'h00);
    add(27346, 0, 146, 34, 0, 1, 1, 8'h00);
    add(28145, 0, 145, 35, 0, 1, 1, 8'h00);
    add(28146, 0, 146, 35, 0, 1, 1, 8'h90);
    add(28147, 1, 147, 35, 0, 1, 1, 8'h00);
    add(28148, 1, 148, 35, 0, 1, 1, 8'h90);
    add(28202, 0, 202, 35, 0, 1, 1, 8'hC8);
    add(28785, 0, 785, 35, 0, 1, 1, 8'h0F);
    add(28786, 0, 786, 35, 0, 1, 1, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_hsync", 32'(if1.hsync), 32'd1);
    chk("reset_rgb", 32'(pins(0)), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    #1;

    foreach (tv[i]) begin
      while (cyc < tv[i].n) tick();
      case (tv[i].sel)
        0: begin
          chk($sformatf("h_count[%0d]", i), 32'(if1.h_count), 32'(tv[i].h));
          chk($sformatf("v_count[%0d]", i), 32'(if1.v_count), 32'(tv[i].v));
          chk($sformatf("frame_start[%0d]", i), 32'(if1.frame_start), 32'(tv[i].fs));
          chk($sformatf("hsync[%0d]", i), 32'(if1.hsync), 32'(tv[i].hs));
          chk($sformatf("vsync[%0d]", i), 32'(if1.vsync), 32'(tv[i].vs));
        end
        1: begin
          chk($sformatf("h_count[%0d]", i), 32'(if3.h_count), 32'(tv[i].h));
          chk($sformatf("v_count[%0d]", i), 32'(if3.v_count), 32'(tv[i].v));
          chk($sformatf("frame_start[%0d]", i), 32'(if3.frame_start), 32'(tv[i].fs));
          chk($sformatf("hsync[%0d]", i), 32'(if3.hsync), 32'(tv[i].hs));
          chk($sformatf("vsync[%0d]", i), 32'(if3.vsync), 32'(tv[i].vs));
        end
        default: begin
          chk($sformatf("h_count[%0d]", i), 32'(ifs.h_count), 32'(tv[i].h));
          chk($sformatf("v_count[%0d]", i), 32'(ifs.v_count), 32'(tv[i].v));
          chk($sformatf("frame_start[%0d]", i), 32'(ifs.frame_start), 32'(tv[i].fs));
          chk($sformatf("hsync[%0d]", i), 32'(ifs.hsync), 32'(tv[i].hs));
          chk($sformatf("vsync[%0d]", i), 32'(ifs.vsync), 32'(tv[i].vs));
        end
      endcase
      chk($sformatf("rgb[%0d]", i), 32'(pins(tv[i].sel)), 32'(tv[i].rgb));
    end

    // Scaled frame is 160 cycles, so 179 strobes by cycle 28786; full frame not yet reached.
    chk("frame_start_count_small", 32'(fss_cnt), 32'd179);
    chk("frame_start_count_full", 32'(fs1_cnt), 32'd0);

    // Mid-frame reset while the pins show live pixels at (400,36).
    while (cyc < 29200) tick();
    chk("pre_rst_h", 32'(if1.h_count), 32'd400);
    chk("pre_rst_v", 32'(if1.v_count), 32'd36);
    chk("pre_rst_rgb1", 32'(pins(0)), 32'h8E);
    chk("pre_rst_rgb3", 32'(pins(1)), 32'h8C);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_hsync", 32'(if1.hsync), 32'd1);
      chk("rst_vsync", 32'(if1.vsync), 32'd1);
      chk("rst_rgb1", 32'(pins(0)), 32'h00);
      chk("rst_rgb3", 32'(pins(1)), 32'h00);
      chk("rst_counts", 32'({if1.h_count, if1.v_count}), 32'd0);
      chk("rst_fs_small", 32'(ifs.frame_start), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    tick();
    chk("post_rst_h", 32'(if1.h_count), 32'd1);
    chk("post_rst_v", 32'(if1.v_count), 32'd0);
    chk("post_rst_hsync", 32'(if1.hsync), 32'd1);
    chk("post_rst_rgb3", 32'(pins(1)), 32'h00);
    tick();
    chk("post_rst_hsync_low", 32'(if1.hsync), 32'd0);
    chk("post_rst_rgb1", 32'(pins(0)), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
